nibble_serial_adder: RTL
========================

Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder that streams operands through one 4-bit carry-lookahead slice, one nibble per cycle, LSB nibble first. A registered carry links successive nibbles. Sits upstream of, and wraps, the 4-bit CLA slice, so wide additions reuse a single slice. Valid/ready handshakes on both the operand and result sides.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4; other values are an elaboration error.
NIBS, WIDTH/4, derived number of RUN cycles; not overridable.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into nibble 0
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  registered result
cout  output  1  carry out of MSB nibble
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at an edge), regardless of state: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, carry reg=0, nibble counter=0. This applies even mid-RUN; the in-flight operation is discarded with no output.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b, cin into shift regs, set carry reg=cin, counter=0, go to RUN.
  - RUN: in_ready=0. Slice inputs are the low nibbles of the A/B shift regs plus the carry reg. Each edge: shift A/B right 4, shift the slice sum into the top of the sum reg, carry reg <= slice cout, counter++. After the edge with counter==NIBS-1, go to DONE.
  - DONE: out_valid=1, and sum and cout (= carry reg) are held stable. On out_valid&out_ready, go to IDLE.
- Latency: out_valid rises exactly NIBS cycles after the accepting edge (4 for WIDTH=16).
- Throughput: one operation per NIBS+2 cycles at best. No accept in the same cycle as result handoff; in_ready is high only in IDLE.
- in_valid outside IDLE is ignored, and a/b/cin changes during RUN have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
- sum/cout are not guaranteed meaningful outside DONE, but are stable-registered (no X) after reset.
- out_ready held low: DONE persists indefinitely; outputs stay stable.

Optional Feature:
Macro OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit) and captures the MSB nibble's bit-3 carry-in. In DONE, ovf = (carry into bit WIDTH-1) XOR cout, i.e. two's-complement signed overflow. Reset value of ovf is 0, and it is valid only while out_valid=1.
- Undefined: no ovf port and no extra logic.

Decomposition:
- Shared package nsa_pkg holds:
  - constant NIB_W=4
  - state typedef {IDLE, RUN, DONE}
  - counter-width function clog2(NIBS)
- One natural sub-module: cla4_slice. It is a pure combinational 4-bit carry-lookahead (a[3:0], b[3:0], cin -> sum[3:0], cout), built from generate/propagate terms, plus an exported c3 (carry into bit 3) for OVERFLOW_FLAG_EN. It is instantiated once.

Test Plan:
- a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0; out_valid exactly 4 cycles after accept; busy high through DONE.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all four nibble boundaries via the carry reg); also a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Then 200 random a/b/cin compared against the reference {cout,sum}=a+b+cin.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands -> out_valid, sum, cout stable; in_ready=0; new operands not captured. Release out_ready -> IDLE next cycle, in_ready=1.
- Assert rst for one cycle after 2 RUN cycles of 0xFFFF+0x0001 -> next cycle state IDLE, out_valid=0, sum=0, cout=0. A following 0x0003+0x0004 returns 0x0007, cout=0.
- With OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. 0x8000+0xFFFF -> sum=0x7FFF, cout=1, ovf=1. 0xFFFF+0x0001 -> ovf=0.

Source files
------------

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter width for a count of n values; never below one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
    c3   = c[3];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder streaming one nibble per cycle through a single CLA slice.
// Optional macro OVERFLOW_FLAG_EN adds a signed-overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef OVERFLOW_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int unsigned NIBS  = WIDTH / NIB_W;
  localparam int unsigned CNT_W = clog2(NIBS);

  // Reject widths that are not a whole number of nibbles.
  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [CNT_W-1:0]   cnt;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;
  logic               slice_c3;
  logic [WIDTH-1:0]   sum_shift;

  // cout doubles as the inter-nibble carry register.
  cla4_slice u_slice (
    .a    (a_sh[NIB_W-1:0]),
    .b    (b_sh[NIB_W-1:0]),
    .cin  (cout),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );

  // New slice nibble enters at the top; after NIBS shifts nibble 0 sits at the bottom.
  always_comb begin
    sum_shift = (sum >> NIB_W) | (WIDTH'(slice_sum) << (WIDTH - NIB_W));
  end

`ifndef OVERFLOW_FLAG_EN
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  // Control FSM plus operand/result datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      cnt       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            cout     <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sh <= a_sh >> NIB_W;
          b_sh <= b_sh >> NIB_W;
          sum  <= sum_shift;
          cout <= slice_cout;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NIBS - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
            ovf       <= slice_c3 ^ slice_cout;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
